// File: rtl/vdp_color_palette.sv
// VDP color palette: 16-entry 9-bit palette with the two-byte R#16 / port #2
// write sequence, pixel source selection (palette, backdrop, SCREEN8 GRB332)
// and a two-stage pipeline that expands the result to 5 bits per channel.
module vdp_color_palette (
    input  logic       clk,
    input  logic       reset,
    input  logic       palette_index_write,
    input  logic [3:0] palette_index,
    input  logic       palette_data_write,
    input  logic [7:0] palette_data,
    input  logic       pixel_valid,
    input  logic       pixel_active,
    input  logic [7:0] screen_mode_display_color,
    input  logic [3:0] sprite_display_color,
    input  logic       sprite_display_color_en,
    input  logic [4:0] reg_screen_mode,
    input  logic       reg_display_on,
    input  logic       reg_color0_opaque,
    input  logic [7:0] reg_backdrop_color,
    output logic [4:0] vdp_r,
    output logic [4:0] vdp_g,
    output logic [4:0] vdp_b,
    output logic       vdp_valid
);

    typedef enum logic {FIRST, SECOND} wr_state_t;

    wr_state_t  state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] lat_r_q, lat_r_d;
    logic [2:0] lat_b_q, lat_b_d;
    logic       commit;
    logic [8:0] pal_q [16];

    // Bits 7 and 3 of the data byte carry no palette information.
    logic unused_data_bits;
    assign unused_data_bits = ^{palette_data[7], palette_data[3]};

    // Power-on palette, stored as {R, G, B} octal digits.
    function automatic logic [8:0] default_entry(input logic [3:0] i);
        case (i)
            4'd0:    return 9'o000;
            4'd1:    return 9'o000;
            4'd2:    return 9'o161;
            4'd3:    return 9'o373;
            4'd4:    return 9'o117;
            4'd5:    return 9'o237;
            4'd6:    return 9'o511;
            4'd7:    return 9'o267;
            4'd8:    return 9'o711;
            4'd9:    return 9'o733;
            4'd10:   return 9'o661;
            4'd11:   return 9'o664;
            4'd12:   return 9'o141;
            4'd13:   return 9'o625;
            4'd14:   return 9'o555;
            default: return 9'o777;
        endcase
    endfunction

    // 3-bit to 5-bit channel expansion by bit replication.
    function automatic logic [4:0] expand3(input logic [2:0] v);
        return {v, v[2:1]};
    endfunction

    // 2-bit to 5-bit channel expansion by bit replication.
    function automatic logic [4:0] expand2(input logic [1:0] b);
        return {b, b, b[1]};
    endfunction

    // Write sequencer next state; an index write always wins and drops the data byte.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lat_r_d = lat_r_q;
        lat_b_d = lat_b_q;
        commit  = 1'b0;
        if (palette_index_write) begin
            idx_d   = palette_index;
            state_d = FIRST;
        end else if (palette_data_write) begin
            if (state_q == FIRST) begin
                lat_r_d = palette_data[6:4];
                lat_b_d = palette_data[2:0];
                state_d = SECOND;
            end else begin
                commit  = 1'b1;
                idx_d   = idx_q + 4'd1;
                state_d = FIRST;
            end
        end
    end

    // Write sequencer state register; reset discards any half-written entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FIRST;
            idx_q   <= 4'd0;
            lat_r_q <= 3'd0;
            lat_b_q <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_r_q <= lat_r_d;
            lat_b_q <= lat_b_d;
        end
    end

    // Palette storage; a commit becomes visible to lookups on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= default_entry(4'(i));
            end
        end else if (commit) begin
            pal_q[idx_q] <= {lat_r_q, palette_data[2:0], lat_b_q};
        end
    end

    // ---- Stage 1: pixel source selection and palette read ----
    logic       is_s8;
    logic       blank;
    logic       use_direct;
    logic [3:0] sel_idx;
    logic [7:0] direct_c;
    logic [8:0] pix_p1_d;

    logic       vld_p1_q;
    logic       direct_p1_q;
    logic [8:0] pix_p1_q;

    assign is_s8 = (reg_screen_mode == 5'b11100);
    assign blank = !reg_display_on || !pixel_active;

    // Choose a palette index or, in SCREEN8, a direct GRB332 color.
    always_comb begin
        sel_idx    = screen_mode_display_color[3:0];
        use_direct = 1'b0;
        direct_c   = reg_backdrop_color;
        if (is_s8) begin
            if (blank) begin
                use_direct = 1'b1;
            end else if (sprite_display_color_en) begin
                sel_idx = sprite_display_color;
            end else if (screen_mode_display_color == 8'h00 && !reg_color0_opaque) begin
                use_direct = 1'b1;
            end else begin
                use_direct = 1'b1;
                direct_c   = screen_mode_display_color;
            end
        end else begin
            if (blank) begin
                sel_idx = reg_backdrop_color[3:0];
            end else if (sprite_display_color_en) begin
                sel_idx = sprite_display_color;
            end else if (screen_mode_display_color[3:0] == 4'd0 && !reg_color0_opaque) begin
                sel_idx = reg_backdrop_color[3:0];
            end
        end
        pix_p1_d = use_direct ? {1'b0, direct_c} : pal_q[sel_idx];
    end

    // Stage 1 register; data only moves with a valid pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= pixel_valid;
        end
        if (pixel_valid) begin
            direct_p1_q <= use_direct;
            pix_p1_q    <= pix_p1_d;
        end
    end

    // ---- Stage 2: channel expansion and output register ----
    logic [4:0] r_p2_d, g_p2_d, b_p2_d;
    logic [4:0] vdp_r_q, vdp_g_q, vdp_b_q;
    logic       vld_p2_q;

    // Direct colors are GRB332; palette entries are RGB333.
    always_comb begin
        if (direct_p1_q) begin
            r_p2_d = expand3(pix_p1_q[4:2]);
            g_p2_d = expand3(pix_p1_q[7:5]);
            b_p2_d = expand2(pix_p1_q[1:0]);
        end else begin
            r_p2_d = expand3(pix_p1_q[8:6]);
            g_p2_d = expand3(pix_p1_q[5:3]);
            b_p2_d = expand3(pix_p1_q[2:0]);
        end
    end

    // Output register; RGB holds its last value between valid pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2_q <= 1'b0;
            vdp_r_q  <= 5'd0;
            vdp_g_q  <= 5'd0;
            vdp_b_q  <= 5'd0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                vdp_r_q <= r_p2_d;
                vdp_g_q <= g_p2_d;
                vdp_b_q <= b_p2_d;
            end
        end
    end

    assign vdp_r     = vdp_r_q;
    assign vdp_g     = vdp_g_q;
    assign vdp_b     = vdp_b_q;
    assign vdp_valid = vld_p2_q;

endmodule

// File: tb/tb_vdp_color_palette.sv
// Scoreboard bench for vdp_color_palette: directed pixels push expected RGB,
// a negedge monitor pops and compares whenever vdp_valid is high.
module tb_vdp_color_palette;

    logic       clk = 1'b0;
    logic       reset;
    logic       palette_index_write;
    logic [3:0] palette_index;
    logic       palette_data_write;
    logic [7:0] palette_data;
    logic       pixel_valid;
    logic       pixel_active;
    logic [7:0] screen_mode_display_color;
    logic [3:0] sprite_display_color;
    logic       sprite_display_color_en;
    logic [4:0] reg_screen_mode;
    logic       reg_display_on;
    logic       reg_color0_opaque;
    logic [7:0] reg_backdrop_color;
    logic [4:0] vdp_r, vdp_g, vdp_b;
    logic       vdp_valid;

    localparam logic [4:0] M0 = 5'b00000;
    localparam logic [4:0] S8 = 5'b11100;

    logic [14:0] exp_q[$];
    int          tag_q[$];
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    vdp_color_palette dut (
        .clk                       (clk),
        .reset                     (reset),
        .palette_index_write       (palette_index_write),
        .palette_index             (palette_index),
        .palette_data_write        (palette_data_write),
        .palette_data              (palette_data),
        .pixel_valid               (pixel_valid),
        .pixel_active              (pixel_active),
        .screen_mode_display_color (screen_mode_display_color),
        .sprite_display_color      (sprite_display_color),
        .sprite_display_color_en   (sprite_display_color_en),
        .reg_screen_mode           (reg_screen_mode),
        .reg_display_on            (reg_display_on),
        .reg_color0_opaque         (reg_color0_opaque),
        .reg_backdrop_color        (reg_backdrop_color),
        .vdp_r                     (vdp_r),
        .vdp_g                     (vdp_g),
        .vdp_b                     (vdp_b),
        .vdp_valid                 (vdp_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (vdp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
                logic [14:0] e;
                int          t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check($sformatf("pix%0d_rgb", t), {17'd0, vdp_r, vdp_g, vdp_b}, {17'd0, e});
            end
        end
    end

    task automatic pix_set(input int tag, input logic [4:0] mode, input logic [7:0] c,
                           input logic sen, input logic [3:0] spr, input logic tp,
                           input logic [7:0] bd, input logic act, input logic disp,
                           input logic [4:0] er, input logic [4:0] eg, input logic [4:0] eb);
        reg_screen_mode           = mode;
        screen_mode_display_color = c;
        sprite_display_color_en   = sen;
        sprite_display_color      = spr;
        reg_color0_opaque         = tp;
        reg_backdrop_color        = bd;
        pixel_active              = act;
        reg_display_on            = disp;
        pixel_valid               = 1'b1;
        exp_q.push_back({er, eg, eb});
        tag_q.push_back(tag);
    endtask

    task automatic pix(input int tag, input logic [4:0] mode, input logic [7:0] c,
                       input logic sen, input logic [3:0] spr, input logic tp,
                       input logic [7:0] bd, input logic act, input logic disp,
                       input logic [4:0] er, input logic [4:0] eg, input logic [4:0] eb);
        pix_set(tag, mode, c, sen, spr, tp, bd, act, disp, er, eg, eb);
        step();
        pixel_valid = 1'b0;
    endtask

    task automatic wr_idx(input logic [3:0] i);
        palette_index_write = 1'b1;
        palette_index       = i;
        step();
        palette_index_write = 1'b0;
    endtask

    task automatic wr_dat(input logic [7:0] d);
        palette_data_write = 1'b1;
        palette_data       = d;
        step();
        palette_data_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        palette_index_write = 1'b0; palette_index = 4'd0;
        palette_data_write = 1'b0;  palette_data = 8'h00;
        pixel_valid = 1'b0; pixel_active = 1'b0;
        screen_mode_display_color = 8'h00;
        sprite_display_color = 4'd0; sprite_display_color_en = 1'b0;
        reg_screen_mode = M0; reg_display_on = 1'b0;
        reg_color0_opaque = 1'b0; reg_backdrop_color = 8'h00;

        step(); step();
        check("reset_valid", {31'd0, vdp_valid}, 32'd0);
        check("reset_rgb", {17'd0, vdp_r, vdp_g, vdp_b}, 32'd0);
        reset = 1'b0;
        step();

        // Entry 15 (777) after reset, with exact two-cycle latency and hold.
        pix(1, M0, 8'h0F, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd31, 5'd31, 5'd31);
        check("latency_cycle1_valid", {31'd0, vdp_valid}, 32'd0);
        step();
        check("latency_cycle2_valid", {31'd0, vdp_valid}, 32'd1);
        step();
        check("hold_valid_low", {31'd0, vdp_valid}, 32'd0);
        check("hold_rgb", {17'd0, vdp_r, vdp_g, vdp_b}, 32'h7fff);

        // Selection priority, non-SCREEN8 and SCREEN8.
        pix(2,  M0, 8'h00, 1'b0, 4'd0,  1'b0, 8'h04, 1'b1, 1'b1, 5'd4,  5'd4,  5'd31);
        pix(3,  M0, 8'h00, 1'b1, 4'd2,  1'b0, 8'h04, 1'b1, 1'b1, 5'd4,  5'd27, 5'd4);
        pix(4,  M0, 8'h0F, 1'b1, 4'd2,  1'b0, 8'h04, 1'b0, 1'b1, 5'd4,  5'd4,  5'd31);
        pix(5,  M0, 8'h00, 1'b0, 4'd0,  1'b1, 8'h04, 1'b1, 1'b1, 5'd0,  5'd0,  5'd0);
        pix(6,  M0, 8'hF5, 1'b0, 4'd0,  1'b0, 8'h04, 1'b1, 1'b1, 5'd9,  5'd13, 5'd31);
        pix(7,  S8, 8'hE3, 1'b0, 4'd0,  1'b0, 8'h00, 1'b1, 1'b1, 5'd0,  5'd31, 5'd31);
        pix(8,  S8, 8'h00, 1'b0, 4'd0,  1'b0, 8'h1C, 1'b1, 1'b1, 5'd31, 5'd0,  5'd0);
        pix(9,  S8, 8'h00, 1'b1, 4'd15, 1'b0, 8'h1C, 1'b1, 1'b1, 5'd31, 5'd31, 5'd31);
        pix(10, S8, 8'hE3, 1'b0, 4'd0,  1'b0, 8'h1C, 1'b0, 1'b1, 5'd31, 5'd0,  5'd0);
        pix(11, S8, 8'h00, 1'b0, 4'd0,  1'b1, 8'h1C, 1'b1, 1'b1, 5'd0,  5'd0,  5'd0);
        pix(12, M0, 8'h0F, 1'b0, 4'd0,  1'b0, 8'hF6, 1'b1, 1'b0, 5'd22, 5'd4,  5'd4);
        repeat (3) step();

        // Index 3 write; lookup on the commit cycle still sees the old entry.
        wr_idx(4'd3);
        wr_dat(8'h52);
        pix_set(13, M0, 8'h03, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd13, 5'd31, 5'd13);
        palette_data_write = 1'b1;
        palette_data       = 8'h04;
        step();
        palette_data_write = 1'b0;
        pixel_valid        = 1'b0;
        pix(14, M0, 8'h03, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd22, 5'd18, 5'd9);
        // Index auto-incremented to 4.
        wr_dat(8'h60);
        wr_dat(8'h03);
        pix(15, M0, 8'h04, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd27, 5'd13, 5'd0);

        // Index wrap 15 -> 0 -> 1.
        wr_idx(4'd15);
        wr_dat(8'h71); wr_dat(8'h02);
        wr_dat(8'h13); wr_dat(8'h05);
        wr_dat(8'h26); wr_dat(8'h04);
        pix(16, M0, 8'h0F, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd31, 5'd9,  5'd4);
        pix(17, M0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h00, 1'b1, 1'b1, 5'd4,  5'd22, 5'd13);
        pix(18, M0, 8'h01, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd9,  5'd18, 5'd27);
        pix(19, M0, 8'h02, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd4,  5'd27, 5'd4);
        repeat (3) step();

        // Reset in state SECOND with a pixel in flight: pixel dropped, byte discarded.
        wr_dat(8'h30);
        reg_screen_mode = M0; screen_mode_display_color = 8'h0F;
        sprite_display_color_en = 1'b0; pixel_active = 1'b1; reg_display_on = 1'b1;
        pixel_valid = 1'b1;
        step();
        pixel_valid = 1'b0;
        reset = 1'b1;
        step(); step();
        check("midreset_valid", {31'd0, vdp_valid}, 32'd0);
        check("midreset_rgb", {17'd0, vdp_r, vdp_g, vdp_b}, 32'd0);
        reset = 1'b0;
        step();
        check("post_reset_no_pulse", {31'd0, vdp_valid}, 32'd0);
        wr_dat(8'h01);
        wr_dat(8'h02);
        pix(20, M0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h00, 1'b1, 1'b1, 5'd0,  5'd9,  5'd4);
        pix(21, M0, 8'h03, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd13, 5'd31, 5'd13);

        // Index write and data write together restart the byte sequence.
        wr_dat(8'h70);
        palette_index_write = 1'b1; palette_index = 4'd6;
        palette_data_write  = 1'b1; palette_data  = 8'h55;
        step();
        palette_index_write = 1'b0;
        palette_data_write  = 1'b0;
        wr_dat(8'h07);
        wr_dat(8'h00);
        pix(22, M0, 8'h06, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0,  5'd0,  5'd31);
        pix(23, M0, 8'h07, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd9,  5'd27, 5'd31);

        repeat (4) step();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
